gen_osc_bank: RTL and testbench

//  Multi-voice oscillator bank. Each voice has its own phase accumulator, frequency, waveform select and gain.

---
 rtl/gen_osc_bank.sv | 169 ++++++++++++++++
 tb/tb_gen_osc_bank.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/gen_osc_bank.sv
// Time-multiplexed oscillator bank: one voice evaluated per clock after each
// sample tick, scaled voices summed into a saturated 16-bit sample with a strobe.
module gen_osc_voice #(
  parameter int ACC_W      = 24,
  parameter int TF_W       = 24,
  parameter int STEP_MUL   = 699,
  parameter int STEP_SHIFT = 1
) (
  input  logic             i_clk48,
  input  logic             i_rst48_n,
  input  logic             en,
  input  logic             sync,
  input  logic             pause,
  input  logic [TF_W-1:0]  targetf,
  output logic [ACC_W-1:0] acc_nxt
);
  localparam int PROD_W = TF_W + 10;

  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  step, acc;

  assign prod = PROD_W'(targetf) * PROD_W'(STEP_MUL);
  assign step = ACC_W'(prod >> STEP_SHIFT);

  // Sync wins over pause; the waveform is taken from this next value.
  always_comb begin
    acc_nxt = acc + step;
    if (sync)       acc_nxt = '0;
    else if (pause) acc_nxt = acc;
  end

  always_ff @(posedge i_clk48) begin
    if (!i_rst48_n) acc <= '0;
    else if (en)    acc <= acc_nxt;
  end
endmodule

module gen_osc_bank #(
  parameter int VOICES     = 4,
  parameter int ACC_W      = 24,
  parameter int TF_W       = 24,
  parameter int CLK_DIV    = 1000,
  parameter int STEP_MUL   = 699,
  parameter int STEP_SHIFT = 1
) (
  input  logic                     i_clk48,
  input  logic                     i_rst48_n,
  input  logic                     i_pause,
  input  logic [VOICES*TF_W-1:0]   i_targetf,
  input  logic [VOICES*2-1:0]      i_wave,
  input  logic [VOICES*8-1:0]      i_gain,
  input  logic [VOICES-1:0]        i_sync,
  output logic signed [15:0]       o_sample,
  output logic                     o_pulse
);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int VI_W  = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int MIX_W = 16 + $clog2(VOICES) + 1;
  localparam logic signed [MIX_W-1:0] S_MAX = MIX_W'(32767);
  localparam logic signed [MIX_W-1:0] S_MIN = MIX_W'(-32768);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  logic [VOICES-1:0][TF_W-1:0]  tf_a;
  logic [VOICES-1:0][1:0]       wave_a;
  logic [VOICES-1:0][7:0]       gain_a;
  logic [VOICES-1:0][ACC_W-1:0] acc_nxt;
  logic [VOICES-1:0]            en;

  assign tf_a   = i_targetf;
  assign wave_a = i_wave;
  assign gain_a = i_gain;

  logic [CNT_W-1:0] cnt;
  logic             tick;

  assign tick = (cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge i_clk48) begin
    if (!i_rst48_n) cnt <= '0;
    else            cnt <= tick ? '0 : cnt + CNT_W'(1);
  end

  state_t                   state_q, state_d;
  logic [VI_W-1:0]          v_q, v_d;
  logic signed [MIX_W-1:0]  mix_q, mix_d, scaled;

  for (genvar i = 0; i < VOICES; i++) begin : g_voice
    assign en[i] = (state_q == CALC) && (v_q == VI_W'(i));
    gen_osc_voice #(
      .ACC_W(ACC_W), .TF_W(TF_W), .STEP_MUL(STEP_MUL), .STEP_SHIFT(STEP_SHIFT)
    ) u_voice (
      .i_clk48  (i_clk48),
      .i_rst48_n(i_rst48_n),
      .en       (en[i]),
      .sync     (i_sync[i]),
      .pause    (i_pause),
      .targetf  (tf_a[i]),
      .acc_nxt  (acc_nxt[i])
    );
  end

  // Shared waveform / gain path for the voice currently in its CALC cycle.
  logic [15:0]        p, tu, m;
  logic [31:0]        sprod, m_full;
  logic signed [15:0] wav;
  logic signed [24:0] prod_g;

  assign p      = 16'(acc_nxt[v_q] >> (ACC_W - 16));
  assign tu     = p[15] ? {~p[14:0], 1'b1} : {p[14:0], 1'b0};
  assign sprod  = 32'(p[14:0]) * (32'd32768 - 32'(p[14:0]));
  assign m_full = sprod >> 13;
  assign m      = (m_full > 32'd32767) ? 16'h7FFF : m_full[15:0];

  always_comb begin
    wav = $signed(p);
    case (wave_a[v_q])
      2'd1:    wav = p[15] ? 16'sh8000 : 16'sh7FFF;
      2'd2:    wav = $signed(tu ^ 16'h8000);
      2'd3:    wav = p[15] ? -$signed(m) : $signed(m);
      default: wav = $signed(p);
    endcase
  end

  assign prod_g = wav * $signed({1'b0, gain_a[v_q]});
  assign scaled = MIX_W'(prod_g >>> 8);

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    mix_d   = mix_q;
    case (state_q)
      IDLE: if (tick) begin
        state_d = CALC;
        v_d     = '0;
        mix_d   = '0;
      end
      CALC: begin
        mix_d = mix_q + scaled;
        if (v_q == VI_W'(VOICES - 1)) state_d = OUT;
        else                          v_d     = v_q + VI_W'(1);
      end
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  function automatic logic signed [15:0] sat16(input logic signed [MIX_W-1:0] x);
    if (x > S_MAX) return 16'sh7FFF;
    if (x < S_MIN) return 16'sh8000;
    return x[15:0];
  endfunction

  always_ff @(posedge i_clk48) begin
    if (!i_rst48_n) begin
      state_q  <= IDLE;
      v_q      <= '0;
      mix_q    <= '0;
      o_sample <= '0;
      o_pulse  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      mix_q   <= mix_d;
      o_pulse <= (state_q == OUT);
      if (state_q == OUT) o_sample <= sat16(mix_q);
    end
  end
endmodule

// File: tb/tb_gen_osc_bank.sv
// Scoreboard bench for gen_osc_bank: directed per-tick voice settings with
// hand-computed samples; a negedge monitor pops and checks on every o_pulse.
module tb_gen_osc_bank;
  logic               clk, rst_n, pause;
  logic [4*24-1:0]    tf;
  logic [7:0]         wv;
  logic [31:0]        gn;
  logic [3:0]         sy;
  logic signed [15:0] o_sample;
  logic               o_pulse;

  gen_osc_bank dut (
    .i_clk48  (clk),
    .i_rst48_n(rst_n),
    .i_pause  (pause),
    .i_targetf(tf),
    .i_wave   (wv),
    .i_gain   (gn),
    .i_sync   (sy),
    .o_sample (o_sample),
    .o_pulse  (o_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;
  int ecnt  = 0;
  int exp_q[$];

  always @(posedge clk) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  task automatic chk(input string name, input int got, input int exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && o_pulse) begin
      if (exp_q.size() == 0) begin
        ntot++;
        $display("FAIL unexpected_pulse: sample %0d at edge %0d, no expectation", o_sample, ecnt);
      end else begin
        chk("sample", int'(o_sample), exp_q.pop_front());
      end
    end
  end

  task automatic set_v(input int v, input int f, input int w, input int g);
    tf[v*24 +: 24] = 24'(f);
    wv[v*2 +: 2]   = 2'(w);
    gn[v*8 +: 8]   = 8'(g);
  endtask

  task automatic wait_pulse(output int at);
    at = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (o_pulse) begin
        at = ecnt;
        break;
      end
    end
    if (at < 0) begin
      ntot++;
      $display("FAIL pulse_timeout: no o_pulse within 3000 cycles");
    end else begin
      @(negedge clk);
      chk("pulse_width", int'(o_pulse), 0);
    end
  endtask

  task automatic tick_exp(input int e, output int at);
    exp_q.push_back(e);
    wait_pulse(at);
  endtask

  int at0, at1;

  initial begin
    rst_n = 1'b0; pause = 1'b0; sy = '0; tf = '0; wv = '0; gn = '0;
    set_v(0, 1000, 0, 255);
    set_v(2, 1000, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_sample", int'(o_sample), 0);
    chk("reset_pulse", int'(o_pulse), 0);
    rst_n = 1'b1;

    // Single audible saw voice at 1 kHz, voice 2 runs silently alongside.
    tick_exp(1359, at0);
    chk("first_pulse_edge", at0, 1005);
    tick_exp(2719, at1);
    chk("pulse_period", at1 - at0, 1000);
    tick_exp(4079, at0);

    pause = 1'b1;
    for (int k = 0; k < 5; k++) tick_exp(4079, at0);
    pause = 1'b0;
    tick_exp(5438, at0);

    // Sync and pause together: voice 2 cleared, voice 0 held.
    pause = 1'b1; sy = 4'b0100; gn[2*8 +: 8] = 8'd255;
    tick_exp(5438, at0);
    pause = 1'b0; sy = '0;
    tick_exp(8158, at0);

    // Four squares in the positive half saturate high, then all flip negative.
    for (int v = 0; v < 4; v++) set_v(v, 1, 1, 255);
    tick_exp(32767, at0);
    sy = 4'hF;
    for (int v = 0; v < 4; v++) set_v(v, 24002, 1, 255);
    tick_exp(32767, at0);
    sy = '0;
    tick_exp(-32768, at0);

    // Waveform points on voice 0 only.
    sy = 4'hF;
    set_v(0, 12001, 2, 255);
    for (int v = 1; v < 4; v++) set_v(v, 0, 0, 0);
    tick_exp(-32640, at0);
    sy = '0;
    set_v(0, 12001, 3, 255);
    tick_exp(32639, at0);
    set_v(0, 12001, 2, 255);
    tick_exp(32639, at0);
    set_v(0, 12001, 3, 255);
    tick_exp(-32640, at0);
    set_v(0, 0, 0, 255);
    tick_exp(-16320, at0);
    set_v(0, 0, 1, 255);
    tick_exp(-32640, at0);
    set_v(0, 0, 0, 128);
    tick_exp(-8192, at1);

    // Reset pulse landing in the CALC window of the next tick.
    set_v(0, 1000, 0, 255);
    repeat (995) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_sample", int'(o_sample), 0);
    chk("midreset_pulse", int'(o_pulse), 0);
    chk("midreset_queue", exp_q.size(), 0);
    rst_n = 1'b1;
    tick_exp(1359, at0);
    chk("post_reset_pulse_edge", at0, 1005);

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
